paddle_motion_ctrl: RTL
=======================

PADDLE_MOTION_CTRL -- requirements
Module: paddle_motion_ctrl

Interface
REQ-001 Parameter SCREEN_H, default 480, playfield height in pixels.
REQ-002 Parameter PADDLE_H, default 80, paddle height in pixels.
REQ-003 Parameter STEP_MIN, default 2, initial move step in pixels per frame.
REQ-004 Parameter STEP_MAX, default 8, saturation step in pixels per frame.
REQ-005 Parameter ACCEL_TICKS, default 8, number of updates at one step before the step increments.
REQ-006 Parameter Y_W, default 10, width of the position outputs.
REQ-007 clk  in  1  sole clock; all logic on its rising edge.
REQ-008 reset  in  1  synchronous, active-low reset.
REQ-009 frame_tick  in  1  one-cycle pulse once per frame, requesting a paddle update.
REQ-010 enable  in  1  game running; low freezes motion.
REQ-011 center_req  in  1  one-cycle pulse that recenters both paddles.
REQ-012 w_down, s_down  in  1 each  left-paddle up/down key held.
REQ-013 up_down, down_down  in  1 each  right-paddle up/down key held.
REQ-014 left_y, right_y  out  Y_W each  paddle top-edge row, registered.
REQ-015 busy  out  1  update sequence in progress.
REQ-016 update_done  out  1  one-cycle pulse when both paddles have been updated.
REQ-017 overrun  out  1  sticky flag: frame_tick arrived while busy.

Function
REQ-018 Both paddles share a single step/add/clamp unit, time-multiplexed by a sequencer with states S_IDLE, S_LEFT, S_RIGHT, S_DONE.
REQ-019 S_IDLE: frame_tick=1 and enable=1 -> snapshot all four key inputs and go to S_LEFT; otherwise stay in S_IDLE.
REQ-020 S_LEFT -> S_RIGHT -> S_DONE -> S_IDLE unconditionally, one cycle each.
REQ-021 Timing, with frame_tick high in cycle 0: new left_y visible in cycle 1, new right_y in cycle 2, update_done high only in cycle 3, busy high in cycles 1-3.
REQ-022 Direction per paddle comes from the snapshot: up only -> UP, down only -> DOWN, both or neither -> HOLD.
REQ-023 Each paddle keeps its own direction register, step register (STEP_MIN..STEP_MAX) and hold counter (0..ACCEL_TICKS-1).
REQ-024 Direction differs from the stored direction, or is HOLD -> step=STEP_MIN and counter=0 before the move is applied.
REQ-025 Same direction as stored: when counter=ACCEL_TICKS-1, counter=0 and the step increments (saturating at STEP_MAX) after the move; otherwise the counter increments.
REQ-026 UP: y = (y >= step) ? y-step : 0.
REQ-027 DOWN: y = min(y+step, SCREEN_H-PADDLE_H), computed at Y_W+1 bits with no wrap.
REQ-028 HOLD: y unchanged.
REQ-029 A frame_tick in any state other than S_IDLE is ignored and sets overrun=1.
REQ-030 center_req has priority over all other activity in any state: next cycle both y=(SCREEN_H-PADDLE_H)/2, state S_IDLE, directions HOLD, steps STEP_MIN, counters 0, busy=0; an aborted sequence produces no update_done.
REQ-031 enable=0 in S_IDLE: frame_tick is ignored, overrun is not set, and directions, steps and counters reset as for HOLD; a sequence already in progress completes.
REQ-032 Key inputs changing during S_LEFT..S_DONE have no effect on the current sequence.

Reset
REQ-033 reset=0 sampled at a clock edge: left_y=right_y=(SCREEN_H-PADDLE_H)/2, state S_IDLE, busy=0, update_done=0, overrun=0, directions HOLD, steps STEP_MIN, counters 0.
REQ-034 Reset takes precedence over center_req and frame_tick; overrun clears only on reset.

Verification (default parameters; max y=400, center=200)
REQ-035 Release reset -> left_y=200, right_y=200, busy=0, overrun=0, update_done=0.
REQ-036 w_down held for 3 ticks -> left_y 198, 196, 194; right_y stays 200; update_done exactly 3 cycles after each tick.
REQ-037 down_down held for 9 ticks -> right_y reaches 216 after tick 8 and 219 after tick 9 (step 2 -> 3).
REQ-038 Clamp: left_y=1 with up -> 0; right_y=399 with down -> 400, and stays 400 on further ticks.
REQ-039 w_down and s_down both held -> left_y unchanged; a later w-only tick moves 2 (step reset).
REQ-040 frame_tick repeated in cycle 1 -> ignored, overrun=1; center_req in cycle 2 -> both 200 next cycle, busy=0, no update_done.

Source files
------------

// File: rtl/paddle_motion_ctrl_if.sv
// Key, control and position signals shared between the paddle controller and its driver.
interface paddle_motion_ctrl_if #(
    parameter int Y_W = 10
);
    logic           frame_tick;
    logic           enable;
    logic           center_req;
    logic           w_down;
    logic           s_down;
    logic           up_down;
    logic           down_down;
    logic [Y_W-1:0] left_y;
    logic [Y_W-1:0] right_y;
    logic           busy;
    logic           update_done;
    logic           overrun;

    modport master (
        output frame_tick, enable, center_req, w_down, s_down, up_down, down_down,
        input  left_y, right_y, busy, update_done, overrun
    );

    modport slave (
        input  frame_tick, enable, center_req, w_down, s_down, up_down, down_down,
        output left_y, right_y, busy, update_done, overrun
    );
endinterface

// File: rtl/paddle_motion_ctrl.sv
// Two-paddle motion controller: one accelerating step/add/clamp unit shared by
// the left and right paddles through a four-state sequencer.
module paddle_motion_ctrl #(
    parameter int SCREEN_H    = 480,
    parameter int PADDLE_H    = 80,
    parameter int STEP_MIN    = 2,
    parameter int STEP_MAX    = 8,
    parameter int ACCEL_TICKS = 8,
    parameter int Y_W         = 10
) (
    input logic                 clk,
    input logic                 reset,
    paddle_motion_ctrl_if.slave bus
);

    localparam int CNT_W  = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;
    localparam int STEP_W = $clog2(STEP_MAX + 1);

    localparam logic [Y_W-1:0]    Y_MAX    = Y_W'(SCREEN_H - PADDLE_H);
    localparam logic [Y_W-1:0]    Y_CENTER = Y_W'((SCREEN_H - PADDLE_H) / 2);
    localparam logic [STEP_W-1:0] STEP_LO  = STEP_W'(STEP_MIN);
    localparam logic [STEP_W-1:0] STEP_HI  = STEP_W'(STEP_MAX);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ACCEL_TICKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_LEFT, S_RIGHT, S_DONE} state_t;
    typedef enum logic [1:0] {DIR_HOLD, DIR_UP, DIR_DOWN} dir_t;

    state_t state;
    state_t state_next;

    // Index 0 is the left paddle, index 1 the right paddle.
    logic [Y_W-1:0]    y_q    [2];
    dir_t              dir_q  [2];
    logic [STEP_W-1:0] step_q [2];
    logic [CNT_W-1:0]  cnt_q  [2];
    logic [1:0]        snap_right;

    logic              sel;
    logic              key_up;
    logic              key_dn;
    logic              do_update;
    dir_t              dir_new;
    logic [STEP_W-1:0] step_base;
    logic [STEP_W-1:0] step_new;
    logic [CNT_W-1:0]  cnt_base;
    logic [CNT_W-1:0]  cnt_new;
    logic [Y_W-1:0]    y_cur;
    logic [Y_W-1:0]    y_new;
    logic [Y_W:0]      y_sum;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (bus.frame_tick && bus.enable) state_next = S_LEFT;
            S_LEFT:  state_next = S_RIGHT;
            S_RIGHT: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (bus.center_req) begin
            state_next = S_IDLE;
        end
    end

    always_comb begin
        bus.busy        = (state != S_IDLE);
        bus.update_done = (state == S_DONE);
        bus.left_y      = y_q[0];
        bus.right_y     = y_q[1];
    end

    // The left paddle is updated on the accepting edge with the live keys, which
    // are its snapshot; the right paddle uses keys captured on that same edge.
    always_comb begin
        sel       = (state == S_LEFT);
        do_update = (state == S_LEFT) || ((state == S_IDLE) && bus.frame_tick && bus.enable);
        key_up    = sel ? snap_right[1] : bus.w_down;
        key_dn    = sel ? snap_right[0] : bus.s_down;

        dir_new = DIR_HOLD;
        if (key_up && !key_dn) begin
            dir_new = DIR_UP;
        end else if (key_dn && !key_up) begin
            dir_new = DIR_DOWN;
        end

        y_cur     = y_q[sel];
        step_base = step_q[sel];
        cnt_base  = cnt_q[sel];
        if ((dir_new != dir_q[sel]) || (dir_new == DIR_HOLD)) begin
            step_base = STEP_LO;
            cnt_base  = '0;
        end

        y_sum = {1'b0, y_cur} + (Y_W + 1)'(step_base);
        y_new = y_cur;
        unique case (dir_new)
            DIR_UP:   y_new = (y_cur >= Y_W'(step_base)) ? (y_cur - Y_W'(step_base)) : '0;
            DIR_DOWN: y_new = (y_sum > {1'b0, Y_MAX}) ? Y_MAX : y_sum[Y_W-1:0];
            default:  y_new = y_cur;
        endcase

        step_new = step_base;
        cnt_new  = cnt_base;
        if (dir_new != DIR_HOLD) begin
            if (cnt_base == CNT_LAST) begin
                cnt_new  = '0;
                step_new = (step_base >= STEP_HI) ? STEP_HI : (step_base + 1'b1);
            end else begin
                cnt_new = cnt_base + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || bus.center_req) begin
            for (int i = 0; i < 2; i++) begin
                y_q[i]    <= Y_CENTER;
                dir_q[i]  <= DIR_HOLD;
                step_q[i] <= STEP_LO;
                cnt_q[i]  <= '0;
            end
            snap_right <= '0;
        end else if (do_update) begin
            y_q[sel]    <= y_new;
            dir_q[sel]  <= dir_new;
            step_q[sel] <= step_new;
            cnt_q[sel]  <= cnt_new;
            if (state == S_IDLE) begin
                snap_right <= {bus.up_down, bus.down_down};
            end
        end else if ((state == S_IDLE) && !bus.enable) begin
            for (int i = 0; i < 2; i++) begin
                dir_q[i]  <= DIR_HOLD;
                step_q[i] <= STEP_LO;
                cnt_q[i]  <= '0;
            end
        end
    end

    // A recenter in the same cycle as a stray tick wins and does not flag overrun.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.overrun <= 1'b0;
        end else if (!bus.center_req && bus.frame_tick && (state != S_IDLE)) begin
            bus.overrun <= 1'b1;
        end
    end

endmodule
